// File: rtl/arb_pkg.sv
// Shared arbitration definitions: FSM state encoding, default sizes and
// the modulo-n pointer increment used after every release.
package arb_pkg;

    localparam int unsigned ARB_IDX_W   = 6;
    localparam int unsigned ARB_NUM_REQ = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Increment modulo n, so the pointer never leaves 0..n-1 even when
    // n is not a power of two.
    function automatic int unsigned next_ptr(input int unsigned idx,
                                             input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: finds the first set request bit scanning
// from ptr upward with wrap-around. The request vector is duplicated,
// shifted right by ptr and truncated, which places bit ptr at position 0.
// A lowest-set-bit encode then gives the offset from ptr, and the offset is
// folded back modulo NUM_REQ.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned IDX_W   = ARB_IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   offset;
    logic               found;
    logic [IDX_W:0]     sum;

    assign rot = NUM_REQ'({req, req} >> ptr);

    // Lowest set bit of the rotated vector is the offset of the winner from ptr.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping modulo NUM_REQ.
    always_comb begin
        sum    = {1'b0, ptr} + {1'b0, offset};
        winner = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
        any    = found;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler for a shared one-hot select resource.
// grant_idx drives the decoder sel; grant_valid qualifies the decoder output.
// The owner keeps the grant until it drops its request, and at least one
// idle cycle separates consecutive grants.
// Optional feature: define HOLD_TIMEOUT_EN to force a release after MAX_HOLD
// cycles of continuous ownership (signalled by a one-cycle timeout pulse).
module rr_grant_scheduler
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = ARB_NUM_REQ,
    parameter int unsigned IDX_W    = ARB_IDX_W,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               timeout
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_valid_q, grant_valid_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_winner;
    logic             owner_req;
    logic [IDX_W-1:0] release_ptr;

`ifdef HOLD_TIMEOUT_EN
    localparam int unsigned HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
`else
    localparam int unsigned hold_unused = MAX_HOLD;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .winner  (pick_winner)
    );

    assign owner_req   = req[grant_idx_q];
    assign release_ptr = IDX_W'(next_ptr(32'(grant_idx_q), NUM_REQ));

    // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
`ifdef HOLD_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_idx_d   = pick_winner;
                    grant_valid_d = 1'b1;
                    state_d       = ST_GRANT;
`ifdef HOLD_TIMEOUT_EN
                    hold_cnt_d    = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = release_ptr;
                    state_d       = ST_IDLE;
                end
`ifdef HOLD_TIMEOUT_EN
                // A normal release above wins over the forced one.
                else if (hold_cnt_q == HOLD_LAST) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = release_ptr;
                    state_d       = ST_IDLE;
                    timeout_d     = 1'b1;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer and grant registers; async reset clears grant_valid at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

`ifdef HOLD_TIMEOUT_EN
    // Hold counter and registered timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (64 requesters).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_rr_grant_scheduler;

    logic        clk;
    logic        rst_n;
    logic [63:0] req;
    logic        grant_valid;
    logic [5:0]  grant_idx;
    logic        timeout;

    int unsigned checks;
    int unsigned errors;

    rr_grant_scheduler #(
        .NUM_REQ  (64),
        .IDX_W    (6),
        .MAX_HOLD (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [5:0] idx);
        check({tag, "_valid"}, 32'(grant_valid), 32'd1);
        check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    endtask

    task automatic expect_idle(input string tag, input logic [5:0] idx);
        check({tag, "_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    endtask

    localparam logic [63:0] ONE = 64'd1;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;

        // Reset state
        #12;
        expect_idle("rst", 6'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        expect_idle("idle_noreq", 6'd0);

        // T2 single request from ptr=0
        req = ONE << 5;
        step();
        expect_grant("t2_grant", 6'd5);
        req = '0;
        step();
        expect_idle("t2_release", 6'd5);
        step();
        expect_idle("t2_idle_hold", 6'd5);
        // ptr should now be 6: requesters 4 and 6 compete, 6 wins
        req = (ONE << 6) | (ONE << 4);
        step();
        expect_grant("t2_ptr6", 6'd6);
        req = '0;
        step();
        expect_idle("t2_rel6", 6'd6);

        // Move ptr to 0 through a grant on 63 (wrap)
        req = ONE << 63;
        step();
        expect_grant("g63", 6'd63);
        req = '0;
        step();
        expect_idle("g63_rel", 6'd63);

        // T3 rotation 2 -> 5 -> 63 -> 2
        req = (ONE << 2) | (ONE << 5) | (ONE << 63);
        step();
        expect_grant("t3_a", 6'd2);
        req = (ONE << 5) | (ONE << 63);
        step();
        expect_idle("t3_a_rel", 6'd2);
        req = (ONE << 2) | (ONE << 5) | (ONE << 63);
        step();
        expect_grant("t3_b", 6'd5);
        req = (ONE << 2) | (ONE << 63);
        step();
        expect_idle("t3_b_rel", 6'd5);
        req = (ONE << 2) | (ONE << 5) | (ONE << 63);
        step();
        expect_grant("t3_c", 6'd63);
        req = (ONE << 2) | (ONE << 5);
        step();
        expect_idle("t3_c_rel", 6'd63);
        req = (ONE << 2) | (ONE << 5) | (ONE << 63);
        step();
        expect_grant("t3_d_wrap", 6'd2);
        req = '0;
        step();
        expect_idle("t3_d_rel", 6'd2);

        // T4 no pre-emption; ptr=3 here
        req = ONE << 10;
        step();
        expect_grant("t4_own10", 6'd10);
        req = (ONE << 10) | (ONE << 3);
        step();
        expect_grant("t4_hold1", 6'd10);
        step();
        expect_grant("t4_hold2", 6'd10);
        req = ONE << 3;
        step();
        expect_idle("t4_rel", 6'd10);
        step();
        expect_grant("t4_wrap3", 6'd3);
        req = '0;
        step();
        expect_idle("t4_rel3", 6'd3);

        // T5 release and new request on the same edge; ptr=4
        req = ONE << 7;
        step();
        expect_grant("t5_own7", 6'd7);
        req = ONE << 8;
        step();
        expect_idle("t5_rel", 6'd7);
        step();
        expect_grant("t5_g8", 6'd8);
        req = '0;
        step();
        expect_idle("t5_rel8", 6'd8);

        // T6 long hold by requester 4; ptr=9 so selection wraps
        req = ONE << 4;
        step();
        expect_grant("t6_g4", 6'd4);
        check("t6_to0", 32'(timeout), 32'd0);
`ifdef HOLD_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            step();
            check("t6_hold_valid", 32'(grant_valid), 32'd1);
            check("t6_hold_to", 32'(timeout), 32'd0);
        end
        step();
        expect_idle("t6_forced", 6'd4);
        check("t6_to_pulse", 32'(timeout), 32'd1);
        step();
        expect_grant("t6_regrant", 6'd4);
        check("t6_to_clear", 32'(timeout), 32'd0);
`else
        for (int k = 1; k < 24; k++) begin
            step();
            check("t6_hold_valid", 32'(grant_valid), 32'd1);
            check("t6_hold_to", 32'(timeout), 32'd0);
        end
        check("t6_hold_idx", 32'(grant_idx), 32'd4);
`endif
        req = '0;
        step();
        check("t6_rel", 32'(grant_valid), 32'd0);

        // T1 async reset mid-grant with all requests active
        req = '1;
        step();
        check("t1_pre_valid", 32'(grant_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("t1_async", 6'd0);
        check("t1_async_to", 32'(timeout), 32'd0);
        @(negedge clk);
        check("t1_still_low", 32'(grant_valid), 32'd0);
        rst_n = 1'b1;
        step();
        expect_grant("t1_ptr0", 6'd0);
        req = ~ONE;
        step();
        expect_idle("t1_rel0", 6'd0);
        step();
        expect_grant("t1_next1", 6'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
